// File: rtl/pc_fetch_unit.sv
// PC register and fetch sequencer: BOOT -> FETCH (memory handshake) -> EXEC, with
// halt/stall/jump overrides and a sticky fetch-timeout flag.
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          MAX_WAIT  = 15,
    parameter int          WAIT_BITS = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] PC_Branch,
    input  logic        Jump,
    input  logic [31:0] Jump_Addr,
    input  logic        Halt,
    input  logic        Stall,
    input  logic        Mem_Ready,
    output logic        Mem_Req,
    output logic [31:0] PC,
    output logic [31:0] PC_next,
    output logic        Instr_Valid,
    output logic        Halted,
    output logic        Fetch_Error
);

    typedef enum logic [1:0] {S_BOOT, S_FETCH, S_EXEC, S_HALT} state_t;

    localparam logic [WAIT_BITS-1:0] WAIT_LIM = WAIT_BITS'((MAX_WAIT > 0) ? MAX_WAIT - 1 : 0);
    localparam logic [WAIT_BITS-1:0] WAIT_ONE = WAIT_BITS'(1);

    state_t                state, state_nxt;
    logic [31:0]           pc, pc_nxt;
    logic [WAIT_BITS-1:0]  wait_cnt, wait_nxt;
    logic                  fetch_error, err_nxt;

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= S_BOOT;
            pc          <= RESET_PC;
            wait_cnt    <= '0;
            fetch_error <= 1'b0;
        end else begin
            state       <= state_nxt;
            pc          <= pc_nxt;
            wait_cnt    <= wait_nxt;
            fetch_error <= err_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        wait_nxt  = wait_cnt;
        err_nxt   = fetch_error;
        case (state)
            S_BOOT: state_nxt = S_FETCH;
            S_FETCH: begin
                if (Mem_Ready) begin
                    state_nxt = S_EXEC;
                    wait_nxt  = '0;
                end else begin
                    wait_nxt = wait_cnt + WAIT_ONE;
                    // Ready on the limit cycle takes the branch above, so no error then.
                    if (MAX_WAIT != 0 && wait_cnt == WAIT_LIM) begin
                        err_nxt   = 1'b1;
                        state_nxt = S_HALT;
                    end
                end
            end
            S_EXEC: begin
                if (Halt) begin
                    state_nxt = S_HALT;
                end else if (!Stall) begin
                    pc_nxt    = Jump ? Jump_Addr : PC_Branch;
                    state_nxt = S_FETCH;
                end
            end
            default: ;
        endcase
    end

    assign PC          = pc;
    assign PC_next     = pc + 32'd1;
    assign Mem_Req     = (state == S_FETCH);
    assign Instr_Valid = (state == S_EXEC);
    assign Halted      = (state == S_HALT);
    assign Fetch_Error = fetch_error;

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
- Program-counter register and instruction-fetch sequencer; sits directly downstream of the branch-select mux.
- Registers the mux's selected next-PC (PC+1 or branch target), applies jump/halt/stall overrides, and handshakes with instruction memory.
- Exports the current PC and PC+1 (PC_next), which feeds back into the branch mux.
- PC is word-addressed: sequential increment is +1.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- MAX_WAIT, 15, fetch-wait cycles before timeout error (0 disables timeout).
- WAIT_BITS, 4, width of wait counter; must hold MAX_WAIT.

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- PC_Branch  in  32  next PC from branch mux (PC+1 or branch target)
- Jump  in  1  control-unit jump request
- Jump_Addr  in  32  absolute jump target
- Halt  in  1  decoded halt instruction
- Stall  in  1  hold current instruction (multi-cycle op in datapath)
- Mem_Ready  in  1  instruction memory: data valid for the requested PC
- Mem_Req  out  1  fetch request to instruction memory, address = PC
- PC  out  32  current PC register
- PC_next  out  32  PC+1, to branch mux
- Instr_Valid  out  1  instruction at PC is valid; datapath executes this cycle
- Halted  out  1  core halted
- Fetch_Error  out  1  sticky fetch-timeout flag

Behaviour:
- One clock domain; all state updates on the rising edge of clock; reset is synchronous and active-high.
- Reset values: PC=RESET_PC, state=S_BOOT, wait_cnt=0, Fetch_Error=0.
  - Moore outputs during S_BOOT: Mem_Req=0, Instr_Valid=0, Halted=0.
- Reset asserted mid-operation (any state, including S_HALT) overrides everything on that edge.
- PC_next = PC + 1, combinational, modulo 2^32 (32'hFFFF_FFFF -> 0).
- Mem_Req, Instr_Valid and Halted decode from the state register only; no input-to-output combinational path.
- States:
  - S_BOOT: one cycle; -> S_FETCH.
  - S_FETCH: Mem_Req=1.
    - Mem_Ready=1 -> S_EXEC, wait_cnt<=0.
    - Otherwise wait_cnt<=wait_cnt+1.
    - If MAX_WAIT!=0 and wait_cnt==MAX_WAIT-1 with Mem_Ready=0: Fetch_Error<=1 and -> S_HALT. The error therefore fires after MAX_WAIT consecutive non-ready cycles.
    - Mem_Ready on the limit cycle wins: no error.
  - S_EXEC: Instr_Valid=1. At the edge ending the cycle, priority is Halt > Stall > Jump > default.
    - Halt: PC held; -> S_HALT.
    - Stall: PC held; stay in S_EXEC (Instr_Valid remains 1).
    - Jump: PC<=Jump_Addr; -> S_FETCH.
    - Default: PC<=PC_Branch; -> S_FETCH.
  - S_HALT: Halted=1, Mem_Req=0, Instr_Valid=0. PC frozen. Only reset exits.
- Minimum instruction time: 2 cycles (FETCH with immediate ready, then EXEC).
- Mem_Ready is ignored outside S_FETCH.
- Jump and branch asserted together: Jump wins.
- Halt and Stall asserted together: Halt wins.
- Fetch_Error is sticky until reset.
- PC changes only on the S_EXEC -> S_FETCH transition or on reset.

Test Plan:
- Reset then sequential run, Mem_Ready tied 1, PC_Branch=PC_next: PC sequence 0,1,2,3 with each value held 2 cycles. Mem_Req and Instr_Valid alternate; Halted=0.
- Branch: at PC=5, PC_Branch=32'h40 during S_EXEC -> next fetch at PC=32'h40. With Jump=1, Jump_Addr=32'h80 on the same cycle -> PC=32'h80 instead (jump priority).
- Stall: Stall=1 for 3 EXEC cycles at PC=7 -> PC stays 7, Instr_Valid=1 for 4 cycles total, then PC=8.
- Memory wait and timeout, MAX_WAIT=15:
  - Mem_Ready low 14 cycles then high -> no error; EXEC follows.
  - Mem_Ready held low -> Fetch_Error=1 and Halted=1 after 15 FETCH cycles.
  - Ready on cycle 15 -> no error.
- Halt and reset: Halt=1 at PC=3 -> Halted=1, PC frozen at 3, Mem_Req=0 indefinitely. Reset pulse -> PC=RESET_PC, Halted=0, Fetch_Error=0, S_BOOT then fetch.
- Wrap: force PC to 32'hFFFF_FFFF via Jump -> PC_next=0. Default advance -> PC=0.
